spi_regbank_slave: RTL and testbench

Parametrised SPI slave register bank, the successor to the fixed 8-bit command / 16-bit data / 3-register summing slave. It has separate command and data chip selects and runs SPI mode 0, MSB first. All SPI inputs are oversampled and synchronised into the single system clock. It exposes NUM_REGS writable registers, per-register readback and a modular sum readback to the fabric.

---
 rtl/spi_regbank_slave_if.sv | 25 ++
 rtl/spi_regbank_slave.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_slave_if.sv
// SPI pin bundle for spi_regbank_slave: master drives clock, data and both chip
// selects; slave drives sdo.
interface spi_regbank_slave_if;
    logic spi_scl;
    logic spi_sdi;
    logic spi_cs_cmd;
    logic spi_cs_data;
    logic spi_sdo;

    modport master (
        output spi_scl,
        output spi_sdi,
        output spi_cs_cmd,
        output spi_cs_data,
        input  spi_sdo
    );

    modport slave (
        input  spi_scl,
        input  spi_sdi,
        input  spi_cs_cmd,
        input  spi_cs_data,
        output spi_sdo
    );
endinterface

// File: rtl/spi_regbank_slave.sv
// Oversampled SPI mode-0 slave with NUM_REGS writable registers and sum readback.
// Optional SPI_FRAME_CHECK_EN enables the saturating malformed-frame counter.
module spi_regbank_slave #(
    parameter int unsigned CMD_W       = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_regbank_slave_if.slave         spi,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    output logic                       wr_pulse,
    output logic [CMD_W-2:0]           wr_addr,
    output logic [7:0]                 frame_err_cnt
);

    localparam int unsigned AW    = CMD_W - 1;
    localparam int unsigned MAXW  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAXW + 2);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        CMD_SHIFT,
        DATA_SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sdi_sync_q, cs_cmd_sync_q, cs_data_sync_q;
    logic                   scl_prev_q;
    logic                   scl_s, sdi_s, cs_cmd_s, cs_data_s;
    logic                   scl_rise, scl_fall;

    logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic [CMD_W-1:0]  pend_cmd_q, pend_cmd_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              sdo_q, sdo_d;
    logic              commit;
    logic              wr_pulse_q;
    logic [AW-1:0]     wr_addr_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [AW-1:0]     pend_addr;
    logic              pend_is_read;
    logic              addr_ok;
    logic [DATA_W-1:0] sum_val;
    logic [DATA_W-1:0] preload_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q     <= '0;
            sdi_sync_q     <= '0;
            // CS syncs reset to "asserted" so a frame already in flight is waited out
            cs_cmd_sync_q  <= '0;
            cs_data_sync_q <= '0;
            scl_prev_q     <= 1'b0;
        end else begin
            scl_sync_q     <= {scl_sync_q[SYNC_STAGES-2:0], spi.spi_scl};
            sdi_sync_q     <= {sdi_sync_q[SYNC_STAGES-2:0], spi.spi_sdi};
            cs_cmd_sync_q  <= {cs_cmd_sync_q[SYNC_STAGES-2:0], spi.spi_cs_cmd};
            cs_data_sync_q <= {cs_data_sync_q[SYNC_STAGES-2:0], spi.spi_cs_data};
            scl_prev_q     <= scl_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_cmd_s  = cs_cmd_sync_q[SYNC_STAGES-1];
    assign cs_data_s = cs_data_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;

    assign pend_addr    = pend_cmd_q[AW-1:0];
    assign pend_is_read = pend_cmd_q[CMD_W-1];
    assign addr_ok      = (pend_addr != '0) && (pend_addr <= AW'(NUM_REGS));

    always_comb begin
        sum_val     = '0;
        preload_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            sum_val = sum_val + regs_q[k];
        end
        if (pend_addr == '0) begin
            preload_val = sum_val;
        end
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (pend_addr == AW'(k + 1)) begin
                preload_val = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_sr_d     = cmd_sr_q;
        data_sr_d    = data_sr_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        load_d       = 1'b0;
        tx_d         = tx_q;
        sdo_d        = 1'b0;
        commit       = 1'b0;

        if (load_q) begin
            tx_d = preload_val;
        end

        unique case (state_q)
            WAIT_IDLE: begin
                if (cs_cmd_s && cs_data_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!cs_cmd_s && !cs_data_s) begin
                    state_d = WAIT_IDLE;
                end else if (!cs_cmd_s) begin
                    state_d = CMD_SHIFT;
                end else if (!cs_data_s) begin
                    state_d = DATA_SHIFT;
                end
            end
            CMD_SHIFT: begin
                if (cs_cmd_s) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(CMD_W)) begin
                        pend_valid_d = 1'b1;
                        pend_cmd_d   = cmd_sr_q;
                        load_d       = cmd_sr_q[CMD_W-1];
                    end
                end else if (scl_rise) begin
                    cmd_sr_d = {cmd_sr_q[CMD_W-2:0], sdi_s};
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA_SHIFT: begin
                if (cs_data_s) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    commit       = (cnt_q == CNT_W'(DATA_W)) && pend_valid_q &&
                                   !pend_is_read && addr_ok;
                end else begin
                    sdo_d = pend_valid_q && pend_is_read && tx_q[DATA_W-1];
                    if (scl_rise) begin
                        data_sr_d = {data_sr_q[DATA_W-2:0], sdi_s};
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (scl_fall) begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT_IDLE;
            cmd_sr_q     <= '0;
            data_sr_q    <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= '0;
            load_q       <= 1'b0;
            tx_q         <= '0;
            sdo_q        <= 1'b0;
            wr_pulse_q   <= 1'b0;
            wr_addr_q    <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cmd_sr_q     <= cmd_sr_d;
            data_sr_q    <= data_sr_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
            load_q       <= load_d;
            tx_q         <= tx_d;
            sdo_q        <= sdo_d;
            wr_pulse_q   <= commit;
            if (commit) begin
                wr_addr_q <= pend_addr;
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (commit && pend_addr == AW'(k + 1)) begin
                    regs_q[k] <= data_sr_q;
                end
            end
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            reg_flat[k*DATA_W +: DATA_W] = regs_q[k];
        end
    end

    assign spi.spi_sdo = sdo_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;

`ifdef SPI_FRAME_CHECK_EN
    logic [7:0] err_cnt_q;
    logic       frame_err;

    assign frame_err = ((state_q == IDLE) && !cs_cmd_s && !cs_data_s) ||
                       ((state_q == CMD_SHIFT) && cs_cmd_s && (cnt_q != CNT_W'(CMD_W))) ||
                       ((state_q == DATA_SHIFT) && cs_data_s && (cnt_q != CNT_W'(DATA_W)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign frame_err_cnt = err_cnt_q;
`else
    assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave: default 8/16/3 instance plus a 6/24/5 instance.
module tb_spi_regbank_slave;

    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b0;
    logic sdi = 1'b0;
    logic cs_cmd = 1'b1;
    logic cs_data = 1'b1;
    logic sel_b = 1'b0;
    logic sdo;

    logic [47:0]  reg_flat_a;
    logic         wr_pulse_a;
    logic [6:0]   wr_addr_a;
    logic [7:0]   err_a;
    logic [119:0] reg_flat_b;
    logic         wr_pulse_b;
    logic [4:0]   wr_addr_b;
    logic [7:0]   err_b;

    int checks = 0;
    int failures = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    spi_regbank_slave_if ifa ();
    spi_regbank_slave_if ifb ();

    assign ifa.spi_scl     = scl;
    assign ifa.spi_sdi     = sdi;
    assign ifa.spi_cs_cmd  = sel_b ? 1'b1 : cs_cmd;
    assign ifa.spi_cs_data = sel_b ? 1'b1 : cs_data;
    assign ifb.spi_scl     = scl;
    assign ifb.spi_sdi     = sdi;
    assign ifb.spi_cs_cmd  = sel_b ? cs_cmd : 1'b1;
    assign ifb.spi_cs_data = sel_b ? cs_data : 1'b1;
    assign sdo = sel_b ? ifb.spi_sdo : ifa.spi_sdo;

    spi_regbank_slave #(.CMD_W(8), .DATA_W(16), .NUM_REGS(3), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .spi(ifa),
        .reg_flat(reg_flat_a), .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a), .frame_err_cnt(err_a)
    );

    spi_regbank_slave #(.CMD_W(6), .DATA_W(24), .NUM_REGS(5), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .spi(ifb),
        .reg_flat(reg_flat_b), .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b), .frame_err_cnt(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_pulse_a) pulses_a++;
        if (wr_pulse_b) pulses_b++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // cs_sel: bit0 = command CS, bit1 = data CS; rst_bit pulses rst_n before that bit (-1: never)
    task automatic spi_frame(input logic [1:0] cs_sel, input int nbits, input logic [31:0] tx,
                             input int rst_bit, output logic [31:0] rx);
        rx = '0;
        if (cs_sel[0]) cs_cmd = 1'b0;
        if (cs_sel[1]) cs_data = 1'b0;
        #(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                #20;
                rst_n = 1'b1;
            end
            sdi = tx[i];
            #(HALF);
            rx = {rx[30:0], sdo};
            scl = 1'b1;
            #(HALF);
            scl = 1'b0;
        end
        #(HALF);
        cs_cmd  = 1'b1;
        cs_data = 1'b1;
        sdi     = 1'b0;
        #(2 * HALF);
    endtask

    logic [31:0] rx;
    int          p0;
    logic [7:0]  exp_err1, exp_err2;

    initial begin
`ifdef SPI_FRAME_CHECK_EN
        exp_err1 = 8'd1;
        exp_err2 = 8'd2;
`else
        exp_err1 = 8'd0;
        exp_err2 = 8'd0;
`endif
        #100;
        rst_n = 1'b1;
        #100;
        check_eq("rst_regs", reg_flat_a, 48'h0);
        check_eq("rst_pulse", wr_pulse_a, 1'b0);
        check_eq("rst_addr", wr_addr_a, 7'h0);
        check_eq("rst_err", err_a, 8'h0);
        check_eq("rst_sdo", sdo, 1'b0);

        // Test 1: three writes, sum readback
        spi_frame(2'b01, 8, 32'h01, -1, rx);
        spi_frame(2'b10, 16, 32'h1234, -1, rx);
        check_eq("w1_pulses", pulses_a, 1);
        check_eq("w1_addr", wr_addr_a, 7'd1);
        spi_frame(2'b01, 8, 32'h02, -1, rx);
        spi_frame(2'b10, 16, 32'h0F0F, -1, rx);
        check_eq("w2_pulses", pulses_a, 2);
        check_eq("w2_addr", wr_addr_a, 7'd2);
        spi_frame(2'b01, 8, 32'h03, -1, rx);
        spi_frame(2'b10, 16, 32'hFFFF, -1, rx);
        check_eq("w3_pulses", pulses_a, 3);
        check_eq("w3_addr", wr_addr_a, 7'd3);
        check_eq("t1_regs", reg_flat_a, 48'hFFFF_0F0F_1234);
        spi_frame(2'b01, 8, 32'h80, -1, rx);
        spi_frame(2'b10, 16, 32'h0, -1, rx);
        check_eq("rd_sum", rx[15:0], 16'h2142);
        check_eq("sdo_idle", sdo, 1'b0);

        // Test 2: register read, out-of-range read, ignored writes
        spi_frame(2'b01, 8, 32'h82, -1, rx);
        spi_frame(2'b10, 16, 32'h0, -1, rx);
        check_eq("rd_reg2", rx[15:0], 16'h0F0F);
        spi_frame(2'b01, 8, 32'h85, -1, rx);
        spi_frame(2'b10, 16, 32'hFFFF, -1, rx);
        check_eq("rd_bad", rx[15:0], 16'h0000);
        spi_frame(2'b01, 8, 32'h00, -1, rx);
        spi_frame(2'b10, 16, 32'hAAAA, -1, rx);
        spi_frame(2'b01, 8, 32'h07, -1, rx);
        spi_frame(2'b10, 16, 32'hAAAA, -1, rx);
        check_eq("badw_pulses", pulses_a, 3);
        check_eq("badw_regs", reg_flat_a, 48'hFFFF_0F0F_1234);
        check_eq("badw_addr", wr_addr_a, 7'd3);

        // Test 3: short command frame
        spi_frame(2'b01, 5, 32'h01, -1, rx);
        spi_frame(2'b10, 16, 32'h5555, -1, rx);
        check_eq("short_pulses", pulses_a, 3);
        check_eq("short_regs", reg_flat_a, 48'hFFFF_0F0F_1234);
        check_eq("short_err", err_a, exp_err1);

        // Test 4: both chip selects together while a read is pending
        spi_frame(2'b01, 8, 32'h81, -1, rx);
        spi_frame(2'b11, 16, 32'hA5A5, -1, rx);
        check_eq("both_sdo", rx[15:0], 16'h0000);
        check_eq("both_pulses", pulses_a, 3);
        check_eq("both_err", err_a, exp_err2);
        spi_frame(2'b01, 8, 32'h01, -1, rx);
        spi_frame(2'b10, 16, 32'hBEEF, -1, rx);
        check_eq("after_pulses", pulses_a, 4);
        check_eq("after_regs", reg_flat_a, 48'hFFFF_0F0F_BEEF);

        // Test 5: reset in the middle of a data frame
        spi_frame(2'b01, 8, 32'h01, -1, rx);
        p0 = pulses_a;
        spi_frame(2'b10, 16, 32'h1357, 8, rx);
        check_eq("rstmid_regs", reg_flat_a, 48'h0);
        check_eq("rstmid_pulses", pulses_a, p0);
        check_eq("rstmid_err", err_a, 8'h0);
        spi_frame(2'b01, 8, 32'h01, -1, rx);
        spi_frame(2'b10, 16, 32'h00FF, -1, rx);
        check_eq("post_rst_regs", reg_flat_a, 48'h0000_0000_00FF);
        check_eq("post_rst_pulses", pulses_a, p0 + 1);
        check_eq("post_rst_addr", wr_addr_a, 7'd1);

        // Test 6: 6/24/5 instance, five all-ones writes then sum readback
        sel_b = 1'b1;
        #(2 * HALF);
        for (int k = 1; k <= 5; k++) begin
            spi_frame(2'b01, 6, 32'(k), -1, rx);
            spi_frame(2'b10, 24, 32'hFFFFFF, -1, rx);
        end
        check_eq("b_pulses", pulses_b, 5);
        check_eq("b_addr", wr_addr_b, 5'd5);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("b_reg%0d", k + 1), reg_flat_b[k*24 +: 24], 24'hFFFFFF);
        end
        spi_frame(2'b01, 6, 32'h20, -1, rx);
        spi_frame(2'b10, 24, 32'h0, -1, rx);
        check_eq("b_rd_sum", rx[23:0], 24'hFFFFFB);
        spi_frame(2'b01, 6, 32'h26, -1, rx);
        spi_frame(2'b10, 24, 32'h0, -1, rx);
        check_eq("b_rd_bad", rx[23:0], 24'h000000);
        check_eq("b_err", err_b, 8'h0);
        check_eq("a_untouched", reg_flat_a, 48'h0000_0000_00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
